// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 constants, receiver state and frame layout
package ps2_pkg;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam int PS2_FRAME_BITS = 11;
  typedef enum logic [1:0] {IDLE, RECV, DONE} rx_state_t;
  typedef struct packed {
    logic       stop;
    logic       parity;
    logic [7:0] data;
    logic       start;
  } ps2_frame_t;
  function automatic logic is_prefix(input logic [7:0] b);
    return b == PS2_EXT || b == PS2_BRK;
  endfunction
endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// ps2_keyboard_rx_if: CPU-side scancode bus; master is the receiver, slave is the CPU decode
interface ps2_keyboard_rx_if #(parameter int FIFO_DEPTH = 8);
  logic [31:0]                 code_data;
  logic                        code_valid;
  logic                        code_rd;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [31:0]                 keyb_char;
  logic                        overflow;
  logic                        overflow_clr;
  logic                        frame_err;
  modport master(output code_data, code_valid, fifo_count, keyb_char, overflow, frame_err,
                 input code_rd, overflow_clr);
  modport slave(input code_data, code_valid, fifo_count, keyb_char, overflow, frame_err,
                output code_rd, overflow_clr);
endinterface

// File: rtl/ps2_keyboard_rx_fifo.sv
// ps2_code_fifo: synchronous show-ahead FIFO; head reads as zero when empty
module ps2_code_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty   = count == '0;
  assign full    = count == CW'(DEPTH);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rp];
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + AW'(do_push);
      rp    <= rp + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  // storage array, written only on an accepted push
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 receiver with E0/F0 assembly and code FIFO; PS2_FRAME_CHECK_EN enables start/stop/parity checking
module ps2_keyboard_rx import ps2_pkg::*; #(
  parameter int FIFO_DEPTH   = 8,
  parameter int TIMEOUT_BITS = 20,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  ps2_keyboard_rx_if.master bus
);
  logic [SYNC_STAGES-1:0] cs, ds;
  logic c_prev, fall, timeout;
  rx_state_t state;
  logic [3:0] cnt;
  logic [TIMEOUT_BITS-1:0] tmo;
  ps2_frame_t sr;
  logic [23:0] acc;
  logic [31:0] nacc, keyb;
  logic ok, push, full, empty, drop, ovf;
  assign fall    = c_prev & ~cs[SYNC_STAGES-1];
  assign timeout = state == RECV && tmo[TIMEOUT_BITS-1];
  // pin synchronisers plus the edge register for falling-edge detection
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cs     <= '1;
      ds     <= '1;
      c_prev <= 1'b1;
    end else begin
      cs     <= {cs[SYNC_STAGES-2:0], ps2_clk};
      ds     <= {ds[SYNC_STAGES-2:0], ps2_data};
      c_prev <= cs[SYNC_STAGES-1];
    end
  // receiver FSM: LSB-first shift, bit count and inactivity abort
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      tmo   <= '0;
      sr    <= '0;
    end else begin
      tmo <= state == RECV ? tmo + 1'b1 : '0;
      if (fall && state != DONE)
        sr <= ps2_frame_t'(PS2_FRAME_BITS'({ds[SYNC_STAGES-1], sr} >> 1));
      case (state)
        IDLE: if (fall) begin
          state <= RECV;
          cnt   <= 4'd1;
        end
        RECV: if (timeout) begin
          state <= IDLE;
          cnt   <= '0;
        end else if (fall) begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'(PS2_FRAME_BITS - 1)) state <= DONE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
`ifdef PS2_FRAME_CHECK_EN
  logic ferr;
  assign ok = ~sr.start & sr.stop & (^{sr.data, sr.parity});
  assign bus.frame_err = ferr;
  // one-cycle pulse for each rejected frame
  always_ff @(posedge clk or posedge reset)
    if (reset) ferr <= 1'b0;
    else ferr <= state == DONE && !ok;
`else
  assign ok = 1'b1;
  assign bus.frame_err = 1'b0;
`endif
  assign nacc = is_prefix(acc[7:0]) ? {acc, sr.data} : {24'b0, sr.data};
  assign push = state == DONE && ok && !is_prefix(sr.data);
  assign drop = push && full && !bus.code_rd;
  // prefix accumulator, sticky last code and sticky overflow
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc  <= '0;
      keyb <= '0;
      ovf  <= 1'b0;
    end else begin
      if (timeout) acc <= '0;
      else if (state == DONE && ok) acc <= is_prefix(sr.data) ? nacc[23:0] : '0;
      if (push) keyb <= nacc;
      ovf <= bus.overflow_clr ? 1'b0 : ovf | drop;
    end
  assign bus.keyb_char  = keyb;
  assign bus.overflow   = ovf;
  assign bus.code_valid = ~empty;
  ps2_code_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (bus.code_rd),
    .din   (nacc),
    .dout  (bus.code_data),
    .full  (full),
    .empty (empty),
    .count (bus.fifo_count)
  );
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: directed PS/2 frames against a queue-based scancode model
module tb_ps2_keyboard_rx;
  localparam int DEPTH = 8;
  localparam int TB = 10;
  localparam int H = 8;
  logic clk = 0, reset = 1, ps2_clk = 1, ps2_data = 1;
  int total = 0, bad = 0, err_seen = 0;
  bit busy = 1;
  logic [31:0] q[$];
  logic [31:0] m_kc = 0, m_acc = 0;
  logic m_ovf = 0;
  ps2_keyboard_rx_if #(.FIFO_DEPTH(DEPTH)) bus();
  ps2_keyboard_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_BITS(TB), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #2;
    if (!busy) begin
      chk("code_valid", 32'(bus.code_valid), 32'(q.size() != 0));
      chk("code_data", bus.code_data, q.size() != 0 ? q[0] : 32'h0);
      chk("fifo_count", 32'(bus.fifo_count), q.size());
      chk("keyb_char", bus.keyb_char, m_kc);
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("frame_err_idle", 32'(bus.frame_err), 32'h0);
    end
    if (bus.frame_err === 1'b1) err_seen++;
  end
  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (H) @(negedge clk);
    ps2_clk = 0;
    repeat (H) @(negedge clk);
    ps2_clk = 1;
  endtask
  task automatic send_raw(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i]);
    ps2_data = 1;
    repeat (H) @(negedge clk);
  endtask
  task automatic model_frame(input logic [7:0] b, input bit bad_par);
    logic [31:0] n;
`ifdef PS2_FRAME_CHECK_EN
    if (bad_par) return;
`endif
    n = (m_acc[7:0] == 8'hE0 || m_acc[7:0] == 8'hF0) ? {m_acc[23:0], b} : {24'h0, b};
    if (b == 8'hE0 || b == 8'hF0) m_acc = n;
    else begin
      m_kc = n;
      if (q.size() < DEPTH) q.push_back(n);
      else m_ovf = 1;
      m_acc = 0;
    end
  endtask
  task automatic frame(input logic [7:0] b, input bit bad_par = 0);
    busy = 1;
    send_raw(b, bad_par, 11);
    model_frame(b, bad_par);
    busy = 0;
  endtask
  task automatic pop();
    busy = 1;
    bus.code_rd = 1;
    @(negedge clk);
    bus.code_rd = 0;
    if (q.size() != 0) q.delete(0);
    busy = 0;
  endtask
  task automatic do_reset();
    busy = 1;
    reset = 1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus.code_valid), 32'h0);
    chk("rst_data", bus.code_data, 32'h0);
    chk("rst_count", 32'(bus.fifo_count), 32'h0);
    chk("rst_kc", bus.keyb_char, 32'h0);
    chk("rst_ovf", 32'(bus.overflow), 32'h0);
    chk("rst_ferr", 32'(bus.frame_err), 32'h0);
    reset = 0;
    q.delete();
    m_kc = 0;
    m_ovf = 0;
    m_acc = 0;
    repeat (2) @(negedge clk);
    busy = 0;
  endtask
  initial begin
    bus.code_rd = 0;
    bus.overflow_clr = 0;
    @(negedge clk);
    do_reset();
    frame(8'h1C);
    chk("make_data", bus.code_data, 32'h0000001C);
    chk("make_valid", 32'(bus.code_valid), 32'h1);
    chk("make_kc", bus.keyb_char, 32'h0000001C);
    pop();
    @(negedge clk);
    chk("pop_empty", 32'(bus.code_valid), 32'h0);
    pop();
    frame(8'hE0);
    chk("no_push_e0", 32'(bus.fifo_count), 32'h0);
    frame(8'hF0);
    chk("no_push_f0", 32'(bus.fifo_count), 32'h0);
    frame(8'h75);
    chk("ext_brk_data", bus.code_data, 32'h00E0F075);
    chk("ext_brk_count", 32'(bus.fifo_count), 32'h1);
    pop();
    frame(8'hF0);
    frame(8'h1C);
    chk("brk_data", bus.code_data, 32'h0000F01C);
    frame(8'hE0);
    frame(8'h74);
    chk("ext_kc", bus.keyb_char, 32'h0000E074);
    pop();
    pop();
    for (int i = 0; i < 9; i++) frame(8'h15 + 8'(i));
    chk("ovf_count", 32'(bus.fifo_count), 32'h8);
    chk("ovf_flag", 32'(bus.overflow), 32'h1);
    chk("ovf_kc", bus.keyb_char, 32'h0000001D);
    chk("ovf_head", bus.code_data, 32'h00000015);
    busy = 1;
    bus.overflow_clr = 1;
    @(negedge clk);
    bus.overflow_clr = 0;
    m_ovf = 0;
    busy = 0;
    @(negedge clk);
    chk("ovf_clr", 32'(bus.overflow), 32'h0);
    repeat (8) pop();
    frame(8'hE0);
    busy = 1;
    send_raw(8'h33, 0, 5);
    repeat (2 ** (TB - 1) + 20) @(negedge clk);
    m_acc = 0;
    busy = 0;
    frame(8'h2A);
    chk("tmo_data", bus.code_data, 32'h0000002A);
    chk("tmo_kc", bus.keyb_char, 32'h0000002A);
    pop();
    err_seen = 0;
    frame(8'h1C, 1);
`ifdef PS2_FRAME_CHECK_EN
    chk("ferr_pulse", err_seen, 32'h1);
    chk("ferr_kc", bus.keyb_char, 32'h0000002A);
    chk("ferr_nopush", 32'(bus.fifo_count), 32'h0);
`else
    chk("nochk_err", err_seen, 32'h0);
    chk("nochk_kc", bus.keyb_char, 32'h0000001C);
    pop();
`endif
    frame(8'hE0);
    do_reset();
    frame(8'h75);
    chk("post_rst_data", bus.code_data, 32'h00000075);
    pop();
    busy = 1;
    send_raw(8'h5A, 0, 4);
    do_reset();
    frame(8'h29);
    chk("mid_rst_data", bus.code_data, 32'h00000029);
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
